// File: rtl/ram_switch_ctrl_if.sv
// Button/switch inputs and RAM-side outputs of ram_switch_ctrl, grouped as one bundle.
// master = the controller, slave = whatever drives the switches and watches the RAM port.
interface ram_switch_ctrl_if #(
    parameter int DATA_WIDTH    = 5,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     btn_n;
    logic [ADDRESS_WIDTH-1:0] sw_addr;
    logic [DATA_WIDTH-1:0]    sw_data;
    logic                     scan_mode;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] address_out;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     busy;
    logic [7:0]               wr_count;

    modport master (
        input  btn_n, sw_addr, sw_data, scan_mode,
        output wr_en, address_out, data_out, busy, wr_count
    );

    modport slave (
        output btn_n, sw_addr, sw_data, scan_mode,
        input  wr_en, address_out, data_out, busy, wr_count
    );
endinterface

// File: rtl/ram_switch_ctrl.sv
// Debounced push-button RAM writer: one wr_en pulse per press, switch address shown otherwise.
// Optional auto address scan is compiled in only when RAM_AUTO_SCAN_EN is defined.
module ram_switch_ctrl #(
    parameter int DATA_WIDTH      = 5,
    parameter int ADDRESS_WIDTH   = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_PERIOD     = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    ram_switch_ctrl_if.master bus
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, WRITE, WAIT_RELEASE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     btn_meta_q, btn_meta_d;
    logic                     btn_s_q, btn_s_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     wr_en_q, wr_en_d;
    logic [7:0]               wr_count_q, wr_count_d;
    logic                     scan_active;
    logic                     scan_step;

`ifdef RAM_AUTO_SCAN_EN
    localparam int                SCAN_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;

    // Scan only owns the address while the button FSM is parked in IDLE.
    assign scan_active = bus.scan_mode && (state_q == IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        scan_cnt_d = '0;
        scan_step  = 1'b0;
        if (scan_active) begin
            if (scan_cnt_q == SCAN_LAST) scan_step = 1'b1;
            else                         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan_cnt_q <= '0;
        else     scan_cnt_q <= scan_cnt_d;
    end
`else
    localparam int unused_scan_period = SCAN_PERIOD;
    logic          unused_scan_mode;

    assign unused_scan_mode = bus.scan_mode;
    assign scan_active      = 1'b0;
    assign scan_step        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt counts stable pressed (DEBOUNCE) or released (WAIT_RELEASE) cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s_q && !scan_active) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!btn_s_q)                state_d = IDLE;
                else if (cnt_q == CNT_LAST)  state_d = WRITE;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            WRITE: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: begin
                if (btn_s_q)                 cnt_d   = '0;
                else if (cnt_q == CNT_LAST)  state_d = IDLE;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered RAM port and the button synchroniser.
    always_comb begin
        btn_meta_d = ~bus.btn_n;
        btn_s_d    = btn_meta_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        wr_count_d = wr_count_q;
        case (state_q)
            IDLE: begin
                data_d = bus.sw_data;
                if (!scan_active)   addr_d = bus.sw_addr;
                else if (scan_step) addr_d = addr_q + ADDRESS_WIDTH'(1);
            end
            DEBOUNCE: begin
                // Tracking continues right up to the WRITE edge, which is the capture.
                addr_d  = bus.sw_addr;
                data_d  = bus.sw_data;
                wr_en_d = (state_d == WRITE);
            end
            WRITE:   wr_count_d = wr_count_q + 8'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_count_q <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.address_out = addr_q;
    assign bus.data_out    = data_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.wr_count    = wr_count_q;

endmodule
